fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the combinational instruction ROM: owns the PC, drives the ROM byte address,
//  and captures each {pc, instruction} pair into a small FIFO that feeds decode over a
//  valid/ready handshake. Handles branch redirects (queue flush) and, optionally, halts on
//  misaligned or out-of-range fetches. Sits between the instruction ROM and the decode stage.
// PARAMETERS
//  MEM_SIZE     1024  ROM size in bytes; power of two, > 4
//  RESET_PC     0     PC loaded on reset; word-aligned
//  QUEUE_DEPTH  2     fetch FIFO entries; power of two, >= 2
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  reset            in   1   synchronous, active-high reset
//  mem_address      out  64  byte address to ROM; always equals the internal PC
//  mem_instruction  in   32  ROM read data, combinational from mem_address
//  redirect_valid   in   1   branch taken: load redirect_pc, flush FIFO
//  redirect_pc      in   64  byte address of branch target
//  out_valid        out  1   FIFO non-empty, head entry presented
//  out_ready        in   1   decode accepts head entry when out_valid & out_ready
//  out_instr        out  32  head entry instruction
//  out_pc           out  64  head entry PC
//  fault            out  1   sticky: illegal fetch address detected (macro-dependent)
// BEHAVIOUR
//  - Reset (sync): pc=RESET_PC, FIFO empty, out_valid=0, out_instr=0, out_pc=0, fault=0,
//    state=RUN. Reset asserted mid-stream discards all queued entries.
//  - States: RUN (fetching), FAULT (stalled). RUN->FAULT on illegal address (macro on).
//    FAULT exits only via reset; redirects are ignored in FAULT.
//  - Fetch (RUN, no redirect): push = !full | pop, pop = out_valid & out_ready. On push,
//    FIFO tail <= {pc, mem_instruction}, pc <= pc + 4. No push -> pc holds.
//  - Full FIFO with simultaneous pop: push and pop same cycle; count unchanged.
//  - Latency: entry fetched in cycle N visible on out_* in cycle N+1 (registered FIFO).
//  - Redirect (RUN): FIFO flushed (count=0), pc <= redirect_pc, no push that cycle,
//    any pop that cycle discarded. Redirect takes priority over fetch and pop.
//  - out_instr/out_pc hold stable while out_valid & !out_ready.
//  - PC arithmetic is 64-bit, wraps modulo 2^64; FIFO pointers wrap modulo QUEUE_DEPTH.
//  - Once in FAULT: no pushes, pc frozen, FIFO still drains to decode.
// CONFIGURATION
//  FETCH_BOUNDS_CHECK_EN defined: before pushing, address is legal iff pc[1:0]==0 and
//    pc+3 < MEM_SIZE; illegal -> no push, fault<=1, state<=FAULT next cycle. A redirect
//    to an illegal pc is checked on the following fetch cycle.
//  FETCH_BOUNDS_CHECK_EN undefined: no check; fault tied 0; state never leaves RUN;
//    out-of-range data (ROM returns X) is pushed as-is.
// TESTING
//  - Reset, out_ready=1, ROM words 0..3 = A,B,C,D -> out_pc 0,4,8,12 with A..D on
//    consecutive cycles starting cycle 1 after reset release.
//  - out_ready=0 for 5 cycles -> out_valid=1, count=2, pc=8, out_pc=0 held; ready=1 -> stream resumes
//    with no loss or duplication.
//  - Full FIFO + out_ready=1 -> push and pop each cycle, count stays 2, pc advances by 4/cycle.
//  - redirect_valid=1, redirect_pc=0x40 while FIFO holds 2 entries -> next cycle out_valid=0,
//    following cycle out_pc=0x40.
//  - Macro on: redirect_pc=0x3FE (misaligned) -> fault=1, no entry with pc 0x3FE, pc stays 0x3FE;
//    redirect_pc=0x3FC -> legal, then pc=0x400 faults.
//  - Reset asserted with FIFO full and fault=1 -> next cycle out_valid=0, fault=0, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the program counter, drives the combinational instruction ROM and
//   captures each {pc, instruction} pair into a small FIFO that feeds decode
//   over a valid/ready handshake. A taken branch (redirect) flushes the FIFO
//   and reloads the PC.
//
// Optional feature (macro FETCH_BOUNDS_CHECK_EN):
//   When defined, a fetch from a misaligned or out-of-range PC is refused.
//   The block then latches a sticky fault and stops fetching until reset.
//   When undefined, no check is made and fault stays 0.
//
// Parameters
//   MEM_SIZE     ROM size in bytes (power of two, > 4)
//   RESET_PC     PC loaded on reset (word aligned)
//   QUEUE_DEPTH  fetch FIFO entries (power of two, >= 2)
//
// Ports
//   clk              clock, all state changes on posedge
//   reset            synchronous active-high reset
//   mem_address      byte address to the ROM (the current PC)
//   mem_instruction  ROM data for mem_address (combinational)
//   redirect_valid   branch taken: load redirect_pc and flush the FIFO
//   redirect_pc      branch target byte address
//   out_valid        FIFO head is valid
//   out_ready        decode accepts the head this cycle
//   out_instr        head instruction
//   out_pc           head PC
//   fault            sticky illegal-fetch flag
module fetch_sequencer #(
  parameter int          MEM_SIZE    = 1024,
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] mem_address,
  input  logic [31:0] mem_instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t             state_reg;
  logic [63:0]        pc_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               fault_reg;

  logic [31:0]        instr_reg [QUEUE_DEPTH];
  logic [63:0]        epc_reg   [QUEUE_DEPTH];

  logic               full;
  logic               pop;
  logic               take_redirect;
  logic               fetch_req;
  logic               addr_legal;
  logic               push;
  logic               fault_hit;

  // The bounds test is always elaborated; CHECK_EN folds it away when the
  // feature is disabled so both builds share one code path.
  // A 65-bit sum keeps pc+3 from wrapping into a small legal value.
  always_comb begin
    addr_legal = 1'b1;
    if (CHECK_EN) begin
      addr_legal = (pc_reg[1:0] == 2'b00) &&
                   (({1'b0, pc_reg} + 65'd3) < 65'(MEM_SIZE));
    end
  end

  assign full          = (count_reg == CNT_W'(QUEUE_DEPTH));
  assign pop           = out_valid & out_ready;
  // Redirects are only honoured while running; a faulted sequencer ignores them.
  assign take_redirect = (state_reg == RUN) & redirect_valid;
  // A fetch is attempted when there is (or will be) room, i.e. !full | pop.
  assign fetch_req     = (state_reg == RUN) & ~redirect_valid & (~full | pop);
  assign push          = fetch_req & addr_legal;
  assign fault_hit     = fetch_req & ~addr_legal;

  // Sequencer state, PC and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= RUN;
      pc_reg     <= RESET_PC;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      fault_reg  <= 1'b0;
    end else if (take_redirect) begin
      // Flush: any pop this cycle is discarded along with the queue.
      pc_reg     <= redirect_pc;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        pc_reg     <= pc_reg + 64'd4;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      if (fault_hit) begin
        state_reg <= FAULT;
        fault_reg <= 1'b1;
      end
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        instr_reg[i] <= '0;
        epc_reg[i]   <= '0;
      end
    end else if (push) begin
      instr_reg[wr_ptr_reg] <= mem_instruction;
      epc_reg[wr_ptr_reg]   <= pc_reg;
    end
  end

  assign mem_address = pc_reg;
  assign out_valid   = (count_reg != '0);
  assign out_instr   = instr_reg[rd_ptr_reg];
  assign out_pc      = epc_reg[rd_ptr_reg];
  assign fault       = fault_reg;

endmodule
